// File: rtl/sprite_bank_reader.sv
// Sprite memory bank: per-element index ROMs and colour palettes behind a
// two-stage valid/ready pipeline that returns one colour per clock.
module sprite_bank_reader #(
  parameter int unsigned           ELEMENTS        = 5,
  parameter int unsigned           ELEM_W          = 3,
  parameter int unsigned           ADDR_W          = 14,
  parameter int unsigned           INDEX_W         = 6,
  parameter int unsigned           COLOR_W         = 12,
  parameter logic [8*ELEMENTS-1:0] SIZE_LIST       = 40'h19_64_14_10_19,
  parameter logic [INDEX_W-1:0]    TRANSPARENT_IDX = '0,
  parameter string                 MEMFILE_PREFIX  = ""
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ELEM_W-1:0]  i_req_element,
  input  logic [ADDR_W-1:0]  i_req_addr,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [COLOR_W-1:0] o_out_color,
  output logic               o_out_transparent,
  output logic               o_out_error,
  output logic [ELEM_W-1:0]  o_out_element,
  input  logic               i_pal_we,
  input  logic [ELEM_W-1:0]  i_pal_element,
  input  logic [INDEX_W-1:0] i_pal_index,
  input  logic [COLOR_W-1:0] i_pal_data
);

  logic               w_stall;
  logic               w_adv;
  logic               w_accept;
  logic [15:0]        w_depth;
  logic               w_req_err;
  logic [INDEX_W-1:0] w_s1_idx;
  logic [COLOR_W-1:0] w_s2_color;

  logic [INDEX_W-1:0] w_rom_dout [ELEMENTS];
  logic [COLOR_W-1:0] w_pal_dout [ELEMENTS];

  logic               r_s1_valid;
  logic [ELEM_W-1:0]  r_s1_elem;
  logic               r_s1_err;
  logic               r_s2_valid;
  logic [ELEM_W-1:0]  r_s2_elem;
  logic               r_s2_err;
  logic [INDEX_W-1:0] r_s2_idx;
  logic               r_out_valid;
  logic [COLOR_W-1:0] r_out_color;
  logic               r_out_transparent;
  logic               r_out_error;
  logic [ELEM_W-1:0]  r_out_element;

  // The whole pipeline freezes while the output holds an unconsumed result.
  assign w_stall     = r_out_valid & ~i_out_ready;
  assign w_adv       = ~w_stall;
  assign w_accept    = i_req_valid & w_adv;
  assign o_req_ready = w_adv;

  always_comb begin
    w_depth = '0;
    for (int e = 0; e < int'(ELEMENTS); e++) begin
      if (i_req_element == ELEM_W'(e + 1)) begin
        w_depth = 16'(SIZE_LIST[8*e +: 8]) * 16'(SIZE_LIST[8*e +: 8]);
      end
    end
  end

  assign w_req_err = (i_req_element == '0) || (32'(i_req_element) > ELEMENTS) ||
                     (32'(i_req_addr) >= 32'(w_depth));

  for (genvar g = 0; g < int'(ELEMENTS); g++) begin : g_elem
    localparam int unsigned Size  = 32'(SIZE_LIST[8*g +: 8]);
    localparam int unsigned Depth = Size * Size;
    localparam int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1;

    logic [INDEX_W-1:0] r_rom [Depth];
    logic [COLOR_W-1:0] r_pal [2**INDEX_W];
    logic [INDEX_W-1:0] r_rom_q;
    logic [COLOR_W-1:0] r_pal_q;
    logic               w_rom_re;
    logic               w_pal_re;
    logic               w_pal_we;

    initial begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_rom[i] = INDEX_W'(i);
      end
    end

    assign w_rom_re = w_accept & ~w_req_err & (i_req_element == ELEM_W'(g + 1));
    assign w_pal_re = w_adv & r_s1_valid & ~r_s1_err & (r_s1_elem == ELEM_W'(g + 1));
    assign w_pal_we = i_pal_we & (i_pal_element == ELEM_W'(g + 1));

    always_ff @(posedge i_clk) begin
      if (w_rom_re) begin
        r_rom_q <= r_rom[i_req_addr[Aw-1:0]];
      end
    end

    // Read and write on the same edge: the read returns the old entry.
    always_ff @(posedge i_clk) begin
      if (w_pal_we) begin
        r_pal[i_pal_index] <= i_pal_data;
      end
      if (w_pal_re) begin
        r_pal_q <= r_pal[w_s1_idx];
      end
    end

    assign w_rom_dout[g] = r_rom_q;
    assign w_pal_dout[g] = r_pal_q;
  end

  always_comb begin
    w_s1_idx = '0;
    if (!r_s1_err) begin
      for (int e = 0; e < int'(ELEMENTS); e++) begin
        if (r_s1_elem == ELEM_W'(e + 1)) begin
          w_s1_idx = w_rom_dout[e];
        end
      end
    end
  end

  always_comb begin
    w_s2_color = '0;
    if (!r_s2_err) begin
      for (int e = 0; e < int'(ELEMENTS); e++) begin
        if (r_s2_elem == ELEM_W'(e + 1)) begin
          w_s2_color = w_pal_dout[e];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_valid        <= 1'b0;
      r_s1_elem         <= '0;
      r_s1_err          <= 1'b0;
      r_s2_valid        <= 1'b0;
      r_s2_elem         <= '0;
      r_s2_err          <= 1'b0;
      r_s2_idx          <= '0;
      r_out_valid       <= 1'b0;
      r_out_color       <= '0;
      r_out_transparent <= 1'b0;
      r_out_error       <= 1'b0;
      r_out_element     <= '0;
    end else if (w_adv) begin
      r_s1_valid        <= w_accept;
      r_s1_elem         <= i_req_element;
      r_s1_err          <= w_req_err;
      r_s2_valid        <= r_s1_valid;
      r_s2_elem         <= r_s1_elem;
      r_s2_err          <= r_s1_err;
      r_s2_idx          <= w_s1_idx;
      r_out_valid       <= r_s2_valid;
      r_out_color       <= w_s2_color;
      r_out_transparent <= r_s2_err | (r_s2_idx == TRANSPARENT_IDX);
      r_out_error       <= r_s2_err;
      r_out_element     <= r_s2_elem;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_color       = r_out_color;
  assign o_out_transparent = r_out_transparent;
  assign o_out_error       = r_out_error;
  assign o_out_element     = r_out_element;

endmodule
